// File: rtl/bdpsk_carrier_sequencer.sv
// BDPSK carrier address sequencer: phase accumulator plus differential +64 offset,
// sequencing one reference symbol followed by data symbols fed over valid/ready.
module bdpsk_carrier_sequencer #(
  parameter int unsigned PHASE_STEP      = 1,
  parameter int unsigned SAMPLES_PER_SYM = 256,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tx_start,
  input  logic             tx_stop,
  input  logic             bit_data,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [6:0]       lut_addr,
  output logic             sample_valid,
  output logic             sym_start,
  output logic             busy,
  output logic             underrun,
  output logic [CNT_W-1:0] sym_count
);

  localparam int unsigned ADDR_W = 7;
  localparam logic [CNT_W-1:0]  LAST_SAMPLE = CNT_W'(SAMPLES_PER_SYM - 1);
  localparam logic [ADDR_W-1:0] STEP        = ADDR_W'(PHASE_STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REF  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   phase_acc, phase_d;
  logic                diff, diff_d;
  logic [CNT_W-1:0]    sample_cnt, cnt_d;
  logic [CNT_W-1:0]    sym_cnt_q, sym_d;
  logic                active;
  logic                boundary;

  assign active   = (state != IDLE);
  assign boundary = active && (sample_cnt == LAST_SAMPLE);

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      phase_acc  <= '0;
      diff       <= 1'b0;
      sample_cnt <= '0;
      sym_cnt_q  <= '0;
    end else begin
      state      <= state_d;
      phase_acc  <= phase_d;
      diff       <= diff_d;
      sample_cnt <= cnt_d;
      sym_cnt_q  <= sym_d;
    end
  end

  // Next-state and outputs; only the handshake/underrun terms look at inputs
  always_comb begin
    state_d      = state;
    phase_d      = phase_acc;
    diff_d       = diff;
    cnt_d        = sample_cnt;
    sym_d        = sym_cnt_q;
    busy         = active;
    sample_valid = active;
    lut_addr     = active ? ADDR_W'(phase_acc + {diff, 6'd0}) : '0;
    sym_start    = active && (sample_cnt == '0);
    bit_ready    = boundary && !tx_stop;
    underrun     = boundary && !tx_stop && !bit_valid;
    sym_count    = sym_cnt_q;

    case (state)
      IDLE: begin
        if (tx_start && !tx_stop) begin
          state_d = REF;
          phase_d = '0;
          diff_d  = 1'b0;
          cnt_d   = '0;
          sym_d   = '0;
        end
      end
      REF, DATA: begin
        if (tx_stop) begin
          state_d = IDLE;
          phase_d = '0;
          diff_d  = 1'b0;
          cnt_d   = '0;
        end else if (boundary && !bit_valid) begin
          state_d = IDLE;
          phase_d = '0;
          diff_d  = 1'b0;
          cnt_d   = '0;
        end else if (boundary) begin
          // Phase keeps running across the boundary; only the offset flips
          state_d = DATA;
          phase_d = ADDR_W'(phase_acc + STEP);
          diff_d  = diff ^ bit_data;
          cnt_d   = '0;
          if (sym_cnt_q != '1) sym_d = CNT_W'(sym_cnt_q + CNT_W'(1));
        end else begin
          phase_d = ADDR_W'(phase_acc + STEP);
          cnt_d   = CNT_W'(sample_cnt + CNT_W'(1));
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bdpsk_carrier_sequencer.sv
// Scoreboard bench: stimulus queues expected carrier samples, monitors pop and compare.
module tb_bdpsk_carrier_sequencer;

  typedef struct packed {
    logic [6:0] lut;
    logic       ss;
    logic       br;
    logic       ur;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;

  logic start_a, stop_a, bd_a, bv_a, br_a, sv_a, ss_a, busy_a, ur_a;
  logic [6:0]  lut_a;
  logic [15:0] cnt_a;
  logic start_b, stop_b, bd_b, bv_b, br_b, sv_b, ss_b, busy_b, ur_b;
  logic [6:0]  lut_b;
  logic [15:0] cnt_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bdpsk_carrier_sequencer dut_a (
    .clk(clk), .reset_n(reset_n), .tx_start(start_a), .tx_stop(stop_a),
    .bit_data(bd_a), .bit_valid(bv_a), .bit_ready(br_a), .lut_addr(lut_a),
    .sample_valid(sv_a), .sym_start(ss_a), .busy(busy_a), .underrun(ur_a),
    .sym_count(cnt_a)
  );

  bdpsk_carrier_sequencer #(.PHASE_STEP(3), .SAMPLES_PER_SYM(50), .CNT_W(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .tx_start(start_b), .tx_stop(stop_b),
    .bit_data(bd_b), .bit_valid(bv_b), .bit_ready(br_b), .lut_addr(lut_b),
    .sample_valid(sv_b), .sym_start(ss_b), .busy(busy_b), .underrun(ur_b),
    .sym_count(cnt_b)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Queue one run of samples starting at absolute sample index k0
  task automatic push(input bit to_b, input int k0, input int n, input int step, input int sps,
                      input bit d, input bit last_ur, input bit last_stop);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      int k;
      k     = k0 + i;
      e.lut = 7'((step * k + (d ? 64 : 0)) % 128);
      e.ss  = ((k % sps) == 0);
      e.br  = ((k % sps) == sps - 1) && !(last_stop && i == n - 1);
      e.ur  = last_ur && (i == n - 1);
      if (to_b) q_b.push_back(e);
      else      q_a.push_back(e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitors: every live sample must match the queue head; idle cycles must be quiet
  always @(negedge clk) begin
    if (reset_n) begin
      if (sv_a) begin
        if (q_a.size() == 0) chk("a_unexpected_sample", 32'(lut_a), 32'hffff_ffff);
        else chk("a_sample", 32'({busy_a, lut_a, ss_a, br_a, ur_a}), 32'({1'b1, q_a.pop_front()}));
      end else begin
        chk("a_idle", 32'({busy_a, lut_a, ss_a, br_a, ur_a}), 32'd0);
      end
      if (sv_b) begin
        if (q_b.size() == 0) chk("b_unexpected_sample", 32'(lut_b), 32'hffff_ffff);
        else chk("b_sample", 32'({busy_b, lut_b, ss_b, br_b, ur_b}), 32'({1'b1, q_b.pop_front()}));
      end else begin
        chk("b_idle", 32'({busy_b, lut_b, ss_b, br_b, ur_b}), 32'd0);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    {start_a, stop_a, bd_a, bv_a} = '0;
    {start_b, stop_b, bd_b, bv_b} = '0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    chk("reset_state_a", 32'({busy_a, sv_a, lut_a, ss_a, br_a, ur_a, cnt_a}), 32'd0);
    chk("reset_state_b", 32'({busy_b, sv_b, lut_b, ss_b, br_b, ur_b, cnt_b}), 32'd0);

    // Idle: offered bit is not taken; start together with stop stays idle
    bv_a = 1'b1; bd_a = 1'b1;
    start_a = 1'b1; stop_a = 1'b1;
    tick(1);
    start_a = 1'b0; stop_a = 1'b0;
    chk("start_with_stop_busy", 32'(busy_a), 32'd0);
    tick(1);
    bv_a = 1'b0;

    // Reset in the middle of a data symbol
    start_a = 1'b1; bv_a = 1'b1; bd_a = 1'b1;
    push(1'b0, 0, 256, 1, 256, 1'b0, 1'b0, 1'b0);
    push(1'b0, 256, 43, 1, 256, 1'b1, 1'b0, 1'b0);
    tick(1);
    start_a = 1'b0;
    tick(299);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({busy_a, sv_a, lut_a, ss_a, br_a, ur_a}), 32'd0);
    chk("async_reset_sym_count", 32'(cnt_a), 32'd0);
    chk("async_reset_drain", 32'(q_a.size()), 32'd0);
    bv_a = 1'b0;
    tick(3);
    reset_n = 1'b1;

    // Restart, then underrun at the end of the reference symbol
    start_a = 1'b1;
    push(1'b0, 0, 256, 1, 256, 1'b0, 1'b1, 1'b0);
    tick(1);
    start_a = 1'b0;
    chk("restart_sym_count", 32'(cnt_a), 32'd0);
    tick(256);
    chk("underrun_exit_busy", 32'({busy_a, sv_a}), 32'd0);
    chk("underrun_sym_count", 32'(cnt_a), 32'd0);
    chk("underrun_drain", 32'(q_a.size()), 32'd0);

    // Bits 1,0,1 after the reference symbol
    start_a = 1'b1; bv_a = 1'b1; bd_a = 1'b1;
    push(1'b0, 0,   256, 1, 256, 1'b0, 1'b0, 1'b0);
    push(1'b0, 256, 256, 1, 256, 1'b1, 1'b0, 1'b0);
    push(1'b0, 512, 256, 1, 256, 1'b1, 1'b0, 1'b0);
    push(1'b0, 768, 256, 1, 256, 1'b0, 1'b1, 1'b0);
    tick(1);
    start_a = 1'b0;
    tick(256); bd_a = 1'b0;
    tick(256); bd_a = 1'b1;
    tick(256); bv_a = 1'b0;
    tick(256);
    chk("three_bits_busy", 32'(busy_a), 32'd0);
    chk("three_bits_sym_count", 32'(cnt_a), 32'd3);
    chk("three_bits_drain", 32'(q_a.size()), 32'd0);

    // Bit offered early is held until the boundary and consumed once
    start_a = 1'b1; bv_a = 1'b0;
    push(1'b0, 0,   256, 1, 256, 1'b0, 1'b0, 1'b0);
    push(1'b0, 256, 256, 1, 256, 1'b1, 1'b1, 1'b0);
    tick(1);
    start_a = 1'b0;
    tick(10); bv_a = 1'b1; bd_a = 1'b1;
    tick(246); bv_a = 1'b0;
    tick(256);
    chk("held_bit_busy", 32'(busy_a), 32'd0);
    chk("held_bit_sym_count", 32'(cnt_a), 32'd1);
    chk("held_bit_drain", 32'(q_a.size()), 32'd0);

    // Stop at data sample 100 with a simultaneous (ignored) start
    start_a = 1'b1; bv_a = 1'b1; bd_a = 1'b0;
    push(1'b0, 0,   256, 1, 256, 1'b0, 1'b0, 1'b0);
    push(1'b0, 256, 101, 1, 256, 1'b0, 1'b0, 1'b1);
    tick(1);
    start_a = 1'b0;
    tick(356);
    stop_a = 1'b1; start_a = 1'b1;
    tick(1);
    stop_a = 1'b0; start_a = 1'b0; bv_a = 1'b0;
    chk("stop_busy", 32'(busy_a), 32'd0);
    chk("stop_sym_count_hold", 32'(cnt_a), 32'd1);
    chk("stop_drain", 32'(q_a.size()), 32'd0);
    start_a = 1'b1;
    push(1'b0, 0, 256, 1, 256, 1'b0, 1'b1, 1'b0);
    tick(1);
    start_a = 1'b0;
    chk("stop_restart_sym_count", 32'(cnt_a), 32'd0);
    tick(256);
    chk("stop_restart_busy", 32'(busy_a), 32'd0);
    chk("stop_restart_drain", 32'(q_a.size()), 32'd0);

    // PHASE_STEP=3, 50 samples per symbol: wrap and +64 offset
    start_b = 1'b1; bv_b = 1'b1; bd_b = 1'b1;
    push(1'b1, 0,  50, 3, 50, 1'b0, 1'b0, 1'b0);
    push(1'b1, 50, 50, 3, 50, 1'b1, 1'b1, 1'b0);
    tick(1);
    start_b = 1'b0;
    tick(50); bv_b = 1'b0;
    tick(50);
    chk("step3_busy", 32'(busy_b), 32'd0);
    chk("step3_sym_count", 32'(cnt_b), 32'd1);
    chk("step3_drain", 32'(q_b.size()), 32'd0);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
